// File: rtl/trigger_pkg.sv
// Shared JK trigger definitions: the {J,K} action encoding and the next-state rule
// used by every bit cell.
`timescale 1ns/1ps
package trigger_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_action_e;

  function automatic logic jk_next(input jk_action_e action, input logic q_cur);
    logic nxt;
    // NOTE: give the result a default first, so no path through the case can infer a latch.
    nxt = q_cur;
    unique case (action)
      JK_HOLD:   nxt = q_cur;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q_cur;
      default:   nxt = q_cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// Single-bit JK register with an asynchronous active-high reset.
// The reset value comes in as a port so one cell serves every bit of the bank.
`timescale 1ns/1ps
module jk_bit_cell
  import trigger_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  input  logic rst_val_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = jk_next(jk_action_e'({j_i, k_i}), q_q);
  end

  // NOTE: use non-blocking assignments for registered state, so every register updates from values taken before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= rst_val_i;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/trigger_rs.sv
// Bank of WIDTH independent clocked JK triggers that share one clock and one reset.
// qn is derived combinationally from q, so it tracks q through reset as well.
`timescale 1ns/1ps
module trigger_rs
  import trigger_pkg::*;
#(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .j_i       (j[i]),
      .k_i       (k[i]),
      .rst_val_i (RESET_VALUE[i]),
      .q_o       (q[i])
    );
  end

  assign qn = ~q;

endmodule

// File: tb/tb_trigger_rs.sv
// Directed and randomized checks of trigger_rs for a 1-bit bank and a 4-bit bank.
// The 4-bit bank uses RESET_VALUE = 4'b1010.
`timescale 1ns/1ps
module tb_trigger_rs;

  localparam logic [3:0] RV4 = 4'b1010;

  logic       clk;
  logic       rst1, rst4;
  logic [0:0] j1, k1, q1, qn1;
  logic [3:0] j4, k4, q4, qn4;

  int total = 0;
  int bad   = 0;
  logic [3:0] model4;
  logic       model1;

  trigger_rs #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .j(j1), .k(k1), .q(q1), .qn(qn1)
  );

  trigger_rs #(.WIDTH(4), .RESET_VALUE(RV4)) dut4 (
    .clk(clk), .rst(rst4), .j(j4), .k(k4), .q(q4), .qn(qn4)
  );

  // Clock with a 0.2 ns period; the first rising edge comes at 0.2 ns.
  initial begin
    clk = 1'b0;
    #0.2;
    forever begin
      clk = 1'b1; #0.1;
      clk = 1'b0; #0.1;
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // JK characteristic equation: Q+ = J & ~Q | ~K & Q.
  function automatic logic [3:0] jk_ref(input logic [3:0] j, input logic [3:0] k,
                                        input logic [3:0] q);
    return (j & ~q) | (~k & q);
  endfunction

  // Drive the 1-bit inputs, wait one rising edge, then sample 0.02 ns after it.
  task automatic edge1(input logic j, input logic k);
    j1 = j; k1 = k;
    @(posedge clk);
    #0.02;
    model1 = jk_ref({3'b0, j}, {3'b0, k}, {3'b0, model1})[0];
  endtask

  task automatic edge4(input logic [3:0] j, input logic [3:0] k);
    j4 = j; k4 = k;
    @(posedge clk);
    #0.02;
    model4 = jk_ref(j, k, model4);
  endtask

  initial begin
    rst1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    rst4 = 1'b1; j4 = 4'b1111; k4 = 4'b0000;
    model1 = 1'b0;
    model4 = RV4;

    // Asynchronous reset takes effect before any clock edge.
    #0.01;
    check("rst_q_noedge", {3'b0, q1}, 4'b0000);
    check("rst_qn_noedge", {3'b0, qn1}, 4'b0001);
    check("rst4_q_noedge", q4, RV4);
    #0.11;
    rst1 = 1'b0;
    @(posedge clk);
    #0.02;
    check("rel_q_hold", {3'b0, q1}, 4'b0000);

    // Full truth table starting from q=0.
    edge1(1'b1, 1'b0); check("tt_set",     {3'b0, q1}, {3'b0, model1});
    edge1(1'b0, 1'b0); check("tt_hold",    {3'b0, q1}, {3'b0, model1});
    edge1(1'b0, 1'b1); check("tt_reset",   {3'b0, q1}, {3'b0, model1});
    edge1(1'b1, 1'b1); check("tt_toggle1", {3'b0, q1}, {3'b0, model1});
    edge1(1'b1, 1'b1); check("tt_toggle2", {3'b0, q1}, {3'b0, model1});
    check("tt_final_zero", {3'b0, q1}, 4'b0000);
    j1 = 1'b0; k1 = 1'b0;

    // A j pulse that lies entirely between two rising edges has no effect.
    #0.03; j1 = 1'b1;
    #0.03; check("mid_q", {3'b0, q1}, 4'b0000);
           check("mid_qn", {3'b0, qn1}, {3'b0, ~q1});
    j1 = 1'b0;
    @(posedge clk);
    #0.02;
    check("mid_after_edge", {3'b0, q1}, 4'b0000);
    check("mid_qn_after", {3'b0, qn1}, 4'b0001);

    // Holding j=k=1 toggles q on every edge.
    for (int i = 0; i < 6; i++) begin
      edge1(1'b1, 1'b1);
      check($sformatf("train_%0d", i), {3'b0, q1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      check($sformatf("train_qn_%0d", i), {3'b0, qn1}, {3'b0, ~model1});
    end

    // A reset pulse between edges clears q at once.
    edge1(1'b1, 1'b0);
    check("pre_pulse_set", {3'b0, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b0;
    #0.03; rst1 = 1'b1;
    #0.01; check("pulse_q", {3'b0, q1}, 4'b0000);
           check("pulse_qn", {3'b0, qn1}, 4'b0001);
    #0.04; rst1 = 1'b0;
    model1 = 1'b0;
    edge1(1'b0, 1'b0);
    check("post_pulse_hold", {3'b0, q1}, 4'b0000);

    // Reset that arrives on a toggle edge wins over the toggle.
    j1 = 1'b1; k1 = 1'b1;
    @(posedge clk);
    rst1 = 1'b1;
    #0.02;
    check("coincide_q", {3'b0, q1}, 4'b0000);
    #0.03; rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
    model1 = 1'b0;
    edge1(1'b0, 1'b0);
    check("coincide_after", {3'b0, q1}, 4'b0000);

    // The 4-bit bank has seen many clock edges with j=1111 while in reset.
    check("rst4_ignores_edges", q4, RV4);
    check("rst4_qn", qn4, ~RV4);
    #0.03; rst4 = 1'b0;
    model4 = RV4;
    edge4(4'b0011, 4'b0101);
    check("w4_mixed", q4, model4);
    check("w4_mixed_const", q4, 4'b1011);
    check("w4_mixed_qn", qn4, ~model4);

    // Random j/k, with occasional reset pulses between edges.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        j4 = 4'($urandom); k4 = 4'($urandom);
        #0.03; rst4 = 1'b1;
        #0.01; check($sformatf("rnd_rst_%0d", n), q4, RV4);
        #0.03; rst4 = 1'b0;
        model4 = RV4;
        @(posedge clk);
        #0.02;
        model4 = jk_ref(j4, k4, model4);
        check($sformatf("rnd_after_rst_%0d", n), q4, model4);
      end else begin
        edge4(4'($urandom), 4'($urandom));
        check($sformatf("rnd_%0d", n), q4, model4);
        check($sformatf("rnd_qn_%0d", n), qn4, ~model4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
